// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch types: the entry bundle handed to decode
// and the sequential fetch stride.
package instr_fetch_unit_pkg;

  localparam logic [31:0] FETCH_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        misaligned;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries.
// Ports: push/pop/wdata/rdata, flush (optionally loading
// wdata as the sole entry), count/full/empty status.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic                   load_i,
  input  fetch_entry_t           wdata_i,
  output fetch_entry_t           rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          we;
  logic [PW-1:0] waddr;
  logic          do_push;
  logic          do_pop;

  assign full_o  = count_q == FULL_CNT;
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Flush wins over push/pop; with load it leaves
  // exactly one entry (the misaligned report).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    we       = 1'b0;
    waddr    = wr_ptr_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      waddr    = '0;
      we       = load_i;
      wr_ptr_d = load_i ? PW'(1) : '0;
      count_d  = load_i ? (PW+1)'(1) : '0;
    end else begin
      we = do_push;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + (PW+1)'(do_push)
                        - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory reads
// into a prefetch FIFO, redirect flush, misaligned report.
// Ports: mem_rd_o/mem_addr_o/mem_data_i/mem_ack_i memory,
// redirect_i/redirect_pc_i control, instr_* decode handshake.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fetch_misaligned_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RV_ALIGNED =
    {RESET_VECTOR[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_REQ,
    S_IDLE,
    S_DROP,
    S_HALT
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic          req_en_q, req_en_d;
  logic          halt_pend_q, halt_pend_d;

  logic          push;
  logic          pop;
  logic          flush;
  logic          load;
  logic          req_out;
  logic          ack;
  logic          misal;
  fetch_entry_t  wdata;
  fetch_entry_t  head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  // req_en_q keeps the bus quiet in the reset cycle
  // while the state register already says REQ.
  assign req_out = req_en_q &&
                   (state_q == S_REQ || state_q == S_DROP);
  assign ack     = req_out && mem_ack_i;
  assign pop     = !empty && instr_ready_i;
  assign misal   = redirect_pc_i[1:0] != 2'b00;

  assign mem_rd_o           = req_out;
  assign mem_addr_o         = mem_addr_q;
  assign instr_valid_o      = !empty;
  assign instr_o            = empty ? '0 : head.instr;
  assign pc_o               = empty ? '0 : head.pc;
  assign fetch_misaligned_o = !empty && head.misaligned;

  always_comb begin
    wdata = '{instr: mem_data_i,
              pc: fetch_pc_q,
              misaligned: 1'b0};
    if (load) begin
      wdata = '{instr: 32'h0,
                pc: redirect_pc_i,
                misaligned: 1'b1};
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    halt_pend_d = halt_pend_q;
    req_en_d    = 1'b1;
    push        = 1'b0;
    flush       = 1'b0;
    load        = 1'b0;
    if (redirect_i) begin
      flush      = 1'b1;
      load       = misal;
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      // An unacked request must still be absorbed
      // before the new target can be fetched.
      if (req_out && !mem_ack_i) begin
        state_d     = S_DROP;
        halt_pend_d = misal;
      end else begin
        state_d     = misal ? S_HALT : S_REQ;
        halt_pend_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + FETCH_STEP;
            if (!(count < CW'(FIFO_DEPTH - 1)) && !pop)
              state_d = S_IDLE;
          end
        end
        S_IDLE: begin
          if (pop || !full) state_d = S_REQ;
        end
        S_DROP: begin
          if (ack) begin
            state_d     = halt_pend_q ? S_HALT : S_REQ;
            halt_pend_d = 1'b0;
          end
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_REQ;
      endcase
    end
  end

  // The bus address stays on the abandoned request
  // while dropping, otherwise it tracks fetch_pc.
  always_comb begin
    mem_addr_d = fetch_pc_d;
    if (state_d == S_DROP) mem_addr_d = mem_addr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RV_ALIGNED;
      mem_addr_q  <= RV_ALIGNED;
      req_en_q    <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      mem_addr_q  <= mem_addr_d;
      req_en_q    <= req_en_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .load_i  (load),
    .wdata_i (wdata),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule
